pll_reset_sequencer: RTL and testbench

//  Sequences the PLL: drives its reset and qualifies its lock output, with

---
 rtl/pll_seq_pkg.sv | 30 +++
 rtl/sync_2ff.sv | 32 +++
 rtl/pll_reset_sequencer.sv | 130 +++++++++++++
 tb/tb_pll_reset_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pll_seq_pkg
// Brief    : State encoding and width helpers for the PLL reset sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_state_e;

    // Wide enough to reach the largest terminal count (max - 1).
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    function automatic int retry_width(input int max_retries);
        return (max_retries < 1) ? 1 : $clog2(max_retries + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Brief    : Two-flop synchroniser for asynchronous level inputs.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pll_reset_sequencer
// Brief    : PLL reset/lock sequencing with retry, sticky fault and sys_rst.
// Revision : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int  RST_CYCLES    = 16,
    parameter int  LOCK_TIMEOUT  = 50000,
    parameter int  STABLE_CYCLES = 1024,
    parameter int  MAX_RETRIES   = 3,
    parameter int  CNT_W         = 8,
    localparam int RW            = retry_width(MAX_RETRIES)
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             fault_clr,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic             fault,
    output logic [2:0]       state,
    output logic [RW-1:0]    retry_cnt,
    output logic [CNT_W-1:0] loss_cnt
);

    localparam int              TW          = timer_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam logic [TW-1:0]   RST_LAST    = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0]   LOCK_LAST   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0]   STABLE_LAST = TW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0]   RETRY_MAX   = RW'(MAX_RETRIES);
    localparam logic [CNT_W-1:0] LOSS_SAT   = {CNT_W{1'b1}};

    logic             locked_s;
    pll_state_e       state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic [CNT_W-1:0] loss_q, loss_d;
    logic             attempt_failed;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d_i (pll_locked),
        .q_o (locked_s)
    );

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q <= PLL_RST;
            timer_q <= '0;
            retry_q <= '0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            loss_q  <= loss_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q + TW'(1);
        retry_d        = retry_q;
        loss_d         = loss_q;
        attempt_failed = 1'b0;

        case (state_q)
            PLL_RST: begin
                if (timer_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // A lock seen on the timeout cycle still counts as a lock.
                if (locked_s)                    state_d = STABLE;
                else if (timer_q == LOCK_LAST)   attempt_failed = 1'b1;
            end
            STABLE: begin
                if (!locked_s) begin
                    attempt_failed = 1'b1;
                end else if (timer_q == STABLE_LAST) begin
                    state_d = RUN;
                    retry_d = '0;
                end
            end
            RUN: begin
                timer_d = '0;
                if (!locked_s) begin
                    state_d = PLL_RST;
                    if (loss_q != LOSS_SAT) loss_d = loss_q + CNT_W'(1);
                end
            end
            FAULT: begin
                timer_d = '0;
                if (fault_clr) begin
                    state_d = PLL_RST;
                    retry_d = '0;
                end
            end
            default: state_d = PLL_RST;
        endcase

        if (attempt_failed) begin
            if (retry_q == RETRY_MAX) begin
                state_d = FAULT;
            end else begin
                state_d = PLL_RST;
                retry_d = retry_q + RW'(1);
            end
        end

        // Shared timer restarts at zero in whichever state comes next.
        if (state_d != state_q) timer_d = '0;
    end

    assign pll_rst   = (state_q == PLL_RST) || (state_q == FAULT);
    assign sys_rst   = (state_q != RUN);
    assign ready     = (state_q == RUN);
    assign fault     = (state_q == FAULT);
    assign state     = state_q;
    assign retry_cnt = retry_q;
    assign loss_cnt  = loss_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_reset_sequencer
// Brief    : Randomised and directed bench with a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_reset_sequencer;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 2;
    localparam int CNT_W         = 8;
    localparam int RW            = 2;
    localparam int LOSS_MAX      = 255;

    localparam int P_RST    = 0;
    localparam int P_WAIT   = 1;
    localparam int P_STABLE = 2;
    localparam int P_RUN    = 3;
    localparam int P_FAULT  = 4;

    logic             refclk = 1'b0;
    logic             rst = 1'b1;
    logic             pll_locked = 1'b0;
    logic             fault_clr = 1'b0;
    logic             pll_rst, sys_rst, ready, fault;
    logic [2:0]       state;
    logic [RW-1:0]    retry_cnt;
    logic [CNT_W-1:0] loss_cnt;
    logic [16:0]      dut_vec;

    int n_checks = 0;
    int n_fails  = 0;

    pll_reset_sequencer #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRIES   (MAX_RETRIES),
        .CNT_W         (CNT_W)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .fault_clr  (fault_clr),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .fault      (fault),
        .state      (state),
        .retry_cnt  (retry_cnt),
        .loss_cnt   (loss_cnt)
    );

    always #5 refclk = ~refclk;

    assign dut_vec = {state, pll_rst, sys_rst, ready, fault, retry_cnt, loss_cnt};

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: phase, time spent in it, attempts and losses.
    int m_phase, m_elapsed, m_retries, m_losses;
    bit m_s0, m_s1;
    bit model_valid = 1'b0;

    task automatic m_enter(input int p);
        m_phase   = p;
        m_elapsed = 0;
    endtask

    task automatic m_fail();
        if (m_retries == MAX_RETRIES) begin
            m_enter(P_FAULT);
        end else begin
            m_retries++;
            m_enter(P_RST);
        end
    endtask

    always @(posedge refclk) begin : ref_model
        bit ls;
        ls   = m_s1;
        m_s1 = m_s0;
        m_s0 = pll_locked;
        if (rst) begin
            m_enter(P_RST);
            m_retries   = 0;
            m_losses    = 0;
            m_s0        = 1'b0;
            m_s1        = 1'b0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            case (m_phase)
                P_RST:    if (m_elapsed + 1 >= RST_CYCLES) m_enter(P_WAIT); else m_elapsed++;
                P_WAIT: begin
                    if (ls)                                  m_enter(P_STABLE);
                    else if (m_elapsed + 1 >= LOCK_TIMEOUT)  m_fail();
                    else                                     m_elapsed++;
                end
                P_STABLE: begin
                    if (!ls) m_fail();
                    else if (m_elapsed + 1 >= STABLE_CYCLES) begin
                        m_retries = 0;
                        m_enter(P_RUN);
                    end else m_elapsed++;
                end
                P_RUN: begin
                    if (!ls) begin
                        m_losses = (m_losses < LOSS_MAX) ? m_losses + 1 : LOSS_MAX;
                        m_enter(P_RST);
                    end
                end
                P_FAULT: begin
                    if (fault_clr) begin
                        m_retries = 0;
                        m_enter(P_RST);
                    end
                end
                default: ;
            endcase
        end
    end

    function automatic logic [16:0] model_vec();
        return {3'(m_phase),
                (m_phase == P_RST) || (m_phase == P_FAULT),
                (m_phase != P_RUN),
                (m_phase == P_RUN),
                (m_phase == P_FAULT),
                2'(m_retries),
                8'(m_losses)};
    endfunction

    always @(negedge refclk) begin
        if (model_valid) check_value("model", dut_vec, model_vec());
    end

    task automatic tick(input int n);
        repeat (n) @(negedge refclk);
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!ready && n < 200) begin
            tick(1);
            n++;
        end
        check_value(tag, ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, lows, exp_loss;

        // Reset state
        rst = 1'b1;
        tick(2);
        check_value("reset_vec", dut_vec, {3'd0, 4'b1100, 2'd0, 8'd0});
        rst = 1'b0;

        // Lock 5 cycles after pll_rst falls; release 11 edges later
        n = 0;
        while (pll_rst && n < 50) begin tick(1); n++; end
        check_value("pll_rst_fall_cycle", n, RST_CYCLES);
        tick(5);
        pll_locked = 1'b1;
        n = 0;
        while (sys_rst && n < 100) begin tick(1); n++; end
        check_value("lock_to_release", n, 3 + STABLE_CYCLES);
        check_value("ready_after_lock", ready, 1);

        // fault_clr in RUN is ignored
        fault_clr = 1'b1; tick(1); fault_clr = 1'b0; tick(2);
        check_value("clr_in_run", dut_vec, {3'd3, 4'b0010, 2'd0, 8'd0});

        // Glitch in STABLE -> retry
        pll_locked = 1'b0; tick(3);
        check_value("loss_sys_rst", sys_rst, 1);
        pll_locked = 1'b1;
        n = 0;
        while (state != 3'd2 && n < 50) begin tick(1); n++; end
        check_value("reach_stable", state, 2);
        tick(2);
        pll_locked = 1'b0; tick(1); pll_locked = 1'b1; tick(2);
        check_value("stable_drop_state", state, 0);
        check_value("stable_drop_retry", retry_cnt, 1);
        wait_ready("relock_run");
        check_value("relock_retry", retry_cnt, 0);

        // Loss-of-lock latency and saturation
        rst = 1'b1; tick(2); rst = 1'b0;
        wait_ready("run_before_losses");
        for (int i = 1; i <= 300; i++) begin
            pll_locked = 1'b0;
            tick(2);
            check_value("loss_edge2", sys_rst, 0);
            tick(1);
            check_value("loss_edge3", sys_rst, 1);
            exp_loss = (i < LOSS_MAX) ? i : LOSS_MAX;
            check_value("loss_cnt", loss_cnt, exp_loss);
            tick($urandom_range(0, 6));
            pll_locked = 1'b1;
            wait_ready("loss_relock");
        end
        check_value("loss_sat", loss_cnt, LOSS_MAX);

        // No lock at all -> three attempts then sticky FAULT
        pll_locked = 1'b0;
        tick(3);
        check_value("fault_path_start", state, 0);
        lows = 0;
        for (int i = 1; i <= 3 * (RST_CYCLES + LOCK_TIMEOUT); i++) begin
            tick(1);
            if (!pll_rst) lows++;
            if (i == 3 * (RST_CYCLES + LOCK_TIMEOUT) - 1) check_value("fault_early", fault, 0);
        end
        check_value("fault_set", fault, 1);
        check_value("fault_retry", retry_cnt, MAX_RETRIES);
        check_value("fault_pll_rst", pll_rst, 1);
        check_value("pll_rst_low_cycles", lows, 3 * LOCK_TIMEOUT);
        tick(10);
        check_value("fault_sticky", {fault, pll_rst}, 2'b11);
        fault_clr = 1'b1; tick(1); fault_clr = 1'b0;
        check_value("fault_clr_vec", dut_vec, {3'd0, 4'b1100, 2'd0, 8'd255});

        // Mid-WAIT_LOCK: fault_clr ignored, then rst wins
        tick(RST_CYCLES + LOCK_TIMEOUT + RST_CYCLES + 9);
        check_value("wait_mid_state", state, 1);
        check_value("wait_mid_retry", retry_cnt, 1);
        fault_clr = 1'b1; tick(1); fault_clr = 1'b0;
        check_value("clr_in_wait", dut_vec, {3'd1, 4'b0100, 2'd1, 8'd255});
        rst = 1'b1; fault_clr = 1'b1; tick(1); rst = 1'b0; fault_clr = 1'b0;
        check_value("rst_mid_wait", dut_vec, {3'd0, 4'b1100, 2'd0, 8'd0});

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) pll_locked = ~pll_locked;
            fault_clr = ($urandom_range(0, 24) == 0);
            rst       = ($urandom_range(0, 599) == 0);
            tick(1);
        end
        rst = 1'b0;
        fault_clr = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
